// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Purpose:
//   Main control FSM for the multicycle RV32I core. Sequences fetch, decode,
//   execute, memory and writeback for lw, sw, R-type ALU, I-type ALU, beq and
//   jal. The shared instruction/data memory uses a req/ready handshake. A
//   cycle with mem_ready low holds the FSM in its current state.
//
// Optional feature (compile-time macro ILLEGAL_INSTR_TRAP_EN):
//   defined   : an unknown opcode in DECODE enters TRAP. TRAP keeps every
//               strobe low and raises illegal_instr. It stays there until
//               reset.
//   undefined : an unknown opcode returns to FETCH as a NOP. TRAP is
//               unreachable and illegal_instr is tied low.
//
// Ports:
//   clk           in   core clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   instr[31:0]   in   instruction register contents
//   zero          in   ALU zero flag
//   mem_ready     in   memory completes the current access this cycle
//   mem_req       out  memory access request
//   mem_write     out  request is a store
//   adr_src       out  address select (0 PC, 1 result)
//   ir_write      out  instruction register load
//   pc_en         out  PC register enable
//   reg_write     out  register file write enable
//   result_src    out  result mux (00 ALUOut, 01 mem data, 10 ALU result)
//   alu_src_a     out  ALU A select (00 PC, 01 old PC, 10 rd1)
//   alu_src_b     out  ALU B select (00 rd2, 01 imm, 10 constant 4)
//   alu_ctrl      out  ALU op (000 add, 001 sub, 010 and, 011 or, 101 slt)
//   imm_src       out  immediate format (00 I, 01 S, 10 B, 11 J)
//   illegal_instr out  sitting in TRAP (feature build only)
//   state_dbg     out  current state encoding
// ---------------------------------------------------------------------------
module multicycle_controller #(
  parameter int unsigned RESET_STATE_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              instr,
  input  logic                     zero,
  input  logic                     mem_ready,
  output logic                     mem_req,
  output logic                     mem_write,
  output logic                     adr_src,
  output logic                     ir_write,
  output logic                     pc_en,
  output logic                     reg_write,
  output logic [1:0]               result_src,
  output logic [1:0]               alu_src_a,
  output logic [1:0]               alu_src_b,
  output logic [2:0]               alu_ctrl,
  output logic [1:0]               imm_src,
  output logic                     illegal_instr,
  output logic [RESET_STATE_W-1:0] state_dbg
);

  typedef enum logic [RESET_STATE_W-1:0] {
    S_FETCH    = RESET_STATE_W'(0),
    S_DECODE   = RESET_STATE_W'(1),
    S_MEMADR   = RESET_STATE_W'(2),
    S_MEMREAD  = RESET_STATE_W'(3),
    S_MEMWB    = RESET_STATE_W'(4),
    S_MEMWRITE = RESET_STATE_W'(5),
    S_EXECUTER = RESET_STATE_W'(6),
    S_EXECUTEI = RESET_STATE_W'(7),
    S_ALUWB    = RESET_STATE_W'(8),
    S_BEQ      = RESET_STATE_W'(9),
    S_JAL      = RESET_STATE_W'(10),
    S_TRAP     = RESET_STATE_W'(11)
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     r_state;
  state_t     w_next_state;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_funct7b5;
  logic [2:0] w_alu_op_r;
  logic [2:0] w_alu_op_i;
  logic [1:0] w_imm_dec;
  logic       w_unused_instr;

  assign w_opcode   = instr[6:0];
  assign w_funct3   = instr[14:12];
  assign w_funct7b5 = instr[30];

  // Register fields and upper immediate bits belong to the datapath.
  assign w_unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  // ALU operation decode. The I-type path never selects sub, because bit 30
  // of an I-type instruction is part of the immediate.
  always_comb begin
    w_alu_op_r = ALU_ADD;
    w_alu_op_i = ALU_ADD;
    unique case (w_funct3)
      3'b000: begin
        w_alu_op_r = w_funct7b5 ? ALU_SUB : ALU_ADD;
        w_alu_op_i = ALU_ADD;
      end
      3'b010: begin
        w_alu_op_r = ALU_SLT;
        w_alu_op_i = ALU_SLT;
      end
      3'b110: begin
        w_alu_op_r = ALU_OR;
        w_alu_op_i = ALU_OR;
      end
      3'b111: begin
        w_alu_op_r = ALU_AND;
        w_alu_op_i = ALU_AND;
      end
      default: begin
        w_alu_op_r = ALU_ADD;
        w_alu_op_i = ALU_ADD;
      end
    endcase
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    w_imm_dec = 2'b00;
    unique case (w_opcode)
      OP_SW:   w_imm_dec = 2'b01;
      OP_BEQ:  w_imm_dec = 2'b10;
      OP_JAL:  w_imm_dec = 2'b11;
      default: w_imm_dec = 2'b00;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_FETCH: begin
        if (mem_ready) w_next_state = S_DECODE;
      end
      S_DECODE: begin
        unique case (w_opcode)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = S_EXECUTER;
          OP_ITYPE:     w_next_state = S_EXECUTEI;
          OP_BEQ:       w_next_state = S_BEQ;
          OP_JAL:       w_next_state = S_JAL;
`ifdef ILLEGAL_INSTR_TRAP_EN
          default:      w_next_state = S_TRAP;
`else
          default:      w_next_state = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        w_next_state = (w_opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        if (mem_ready) w_next_state = S_MEMWB;
      end
      S_MEMWRITE: begin
        if (mem_ready) w_next_state = S_FETCH;
      end
      S_MEMWB, S_ALUWB, S_BEQ: begin
        w_next_state = S_FETCH;
      end
      S_EXECUTER, S_EXECUTEI, S_JAL: begin
        w_next_state = S_ALUWB;
      end
      S_TRAP: begin
`ifdef ILLEGAL_INSTR_TRAP_EN
        w_next_state = S_TRAP;
`else
        w_next_state = S_FETCH;
`endif
      end
      default: begin
        w_next_state = S_FETCH;
      end
    endcase
  end

  // Output logic. Every output is also gated by rst_n. Asserting reset then
  // drops the strobes in the same instant, without waiting for a clock edge.
  always_comb begin
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_en         = 1'b0;
    reg_write     = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_ctrl      = ALU_ADD;
    imm_src       = 2'b00;
    illegal_instr = 1'b0;
    if (rst_n) begin
      imm_src = w_imm_dec;
      unique case (r_state)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = mem_ready;
          pc_en      = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
        end
        S_MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
        end
        S_EXECUTER: begin
          alu_src_a = 2'b10;
          alu_ctrl  = w_alu_op_r;
        end
        S_EXECUTEI: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          alu_ctrl  = w_alu_op_i;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
        end
        S_BEQ: begin
          alu_src_a = 2'b10;
          alu_ctrl  = ALU_SUB;
          pc_en     = zero;
        end
        S_JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_en     = 1'b1;
        end
        S_TRAP: begin
`ifdef ILLEGAL_INSTR_TRAP_EN
          illegal_instr = 1'b1;
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign state_dbg = rst_n ? r_state : '0;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller. Each table row is
// one clock cycle. It holds the inputs applied in that cycle and the state
// and outputs expected in that cycle.
module tb_multicycle_controller;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_write, adr_src, ir_write, pc_en, reg_write;
  logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0]  alu_ctrl;
  logic        illegal_instr;
  logic [3:0]  state_dbg;

  multicycle_controller #(.RESET_STATE_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr         (instr),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_write     (mem_write),
    .adr_src       (adr_src),
    .ir_write      (ir_write),
    .pc_en         (pc_en),
    .reg_write     (reg_write),
    .result_src    (result_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_ctrl      (alu_ctrl),
    .imm_src       (imm_src),
    .illegal_instr (illegal_instr),
    .state_dbg     (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // outs = {mem_req, mem_write, adr_src, ir_write, pc_en, reg_write,
  //         result_src, alu_src_a, alu_src_b, alu_ctrl, imm_src, illegal}
  typedef struct {
    logic [31:0] ins;
    logic        z;
    logic        r;
    logic [3:0]  st;
    logic [17:0] outs;
  } vec_t;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_AND  = 32'h0020F1B3;
  localparam logic [31:0] I_OR   = 32'h0020E1B3;
  localparam logic [31:0] I_SLT  = 32'h0020A1B3;
  localparam logic [31:0] I_SLL  = 32'h002091B3;
  localparam logic [31:0] I_ADDI = 32'h40008093;
  localparam logic [31:0] I_SLTI = 32'h0020A093;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_SW   = 32'h0030A223;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_ILL  = 32'h0000007F;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl[$];

  function automatic vec_t mk(input logic [31:0] ins, input logic z, input logic r,
                              input logic [3:0] st,
                              input logic req, input logic wr, input logic adr,
                              input logic ir, input logic pc, input logic rw,
                              input logic [1:0] rs, input logic [1:0] sa,
                              input logic [1:0] sb, input logic [2:0] ac,
                              input logic [1:0] imm, input logic ill);
    vec_t v;
    v.ins  = ins;
    v.z    = z;
    v.r    = r;
    v.st   = st;
    v.outs = {req, wr, adr, ir, pc, rw, rs, sa, sb, ac, imm, ill};
    return v;
  endfunction

  // FETCH row: request at PC, PC+4 through the ALU, strobes follow mem_ready.
  function automatic vec_t fetch(input logic [31:0] ins, input logic r,
                                 input logic [1:0] imm);
    return mk(ins, 1'b0, r, 4'd0, 1'b1, 1'b0, 1'b0, r, r, 1'b0,
              2'b10, 2'b00, 2'b10, 3'b000, imm, 1'b0);
  endfunction

  function automatic vec_t decode(input logic [31:0] ins, input logic [1:0] imm);
    return mk(ins, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              2'b00, 2'b01, 2'b01, 3'b000, imm, 1'b0);
  endfunction

  function automatic vec_t aluwb(input logic [31:0] ins, input logic [1:0] imm);
    return mk(ins, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
              2'b00, 2'b00, 2'b00, 3'b000, imm, 1'b0);
  endfunction

  function automatic vec_t exr(input logic [31:0] ins, input logic [2:0] ac);
    return mk(ins, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              2'b00, 2'b10, 2'b00, ac, 2'b00, 1'b0);
  endfunction

  function automatic logic [17:0] act_outs();
    return {mem_req, mem_write, adr_src, ir_write, pc_en, reg_write,
            result_src, alu_src_a, alu_src_b, alu_ctrl, imm_src, illegal_instr};
  endfunction

  // Drive a row, compare before the next rising edge, then advance one cycle.
  task automatic run_row(input vec_t v, input string name);
    instr     = v.ins;
    zero      = v.z;
    mem_ready = v.r;
    #3;
    n_tests++;
    if (state_dbg !== v.st) begin
      n_fail++;
      $display("FAIL %s state: got %0d want %0d", name, state_dbg, v.st);
    end
    n_tests++;
    if (act_outs() !== v.outs) begin
      n_fail++;
      $display("FAIL %s outs: got %b want %b", name, act_outs(), v.outs);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_zero(input string name);
    n_tests++;
    if (act_outs() !== 18'd0 || state_dbg !== 4'd0) begin
      n_fail++;
      $display("FAIL %s: got outs %b state %0d want outs 0 state 0",
               name, act_outs(), state_dbg);
    end
  endtask

  initial begin
    // add: 0,1,6,8
    tbl.push_back(fetch(I_ADD, 1'b1, 2'b00));
    tbl.push_back(decode(I_ADD, 2'b00));
    tbl.push_back(exr(I_ADD, 3'b000));
    tbl.push_back(aluwb(I_ADD, 2'b00));
    // lw with one fetch stall and two MEMREAD stalls
    tbl.push_back(fetch(I_LW, 1'b0, 2'b00));
    tbl.push_back(fetch(I_LW, 1'b1, 2'b00));
    tbl.push_back(decode(I_LW, 2'b00));
    tbl.push_back(mk(I_LW, 0, 1, 4'd2, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0));
    tbl.push_back(mk(I_LW, 0, 0, 4'd3, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0));
    tbl.push_back(mk(I_LW, 0, 0, 4'd3, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0));
    tbl.push_back(mk(I_LW, 0, 1, 4'd3, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0));
    tbl.push_back(mk(I_LW, 0, 1, 4'd4, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 0));
    // beq taken
    tbl.push_back(fetch(I_BEQ, 1'b1, 2'b10));
    tbl.push_back(decode(I_BEQ, 2'b10));
    tbl.push_back(mk(I_BEQ, 1, 1, 4'd9, 0, 0, 0, 0, 1, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0));
    // beq not taken
    tbl.push_back(fetch(I_BEQ, 1'b1, 2'b10));
    tbl.push_back(decode(I_BEQ, 2'b10));
    tbl.push_back(mk(I_BEQ, 0, 1, 4'd9, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0));
    // R-type ALU decode
    tbl.push_back(fetch(I_SUB, 1'b1, 2'b00));
    tbl.push_back(decode(I_SUB, 2'b00));
    tbl.push_back(exr(I_SUB, 3'b001));
    tbl.push_back(aluwb(I_SUB, 2'b00));
    tbl.push_back(fetch(I_AND, 1'b1, 2'b00));
    tbl.push_back(decode(I_AND, 2'b00));
    tbl.push_back(exr(I_AND, 3'b010));
    tbl.push_back(aluwb(I_AND, 2'b00));
    tbl.push_back(fetch(I_OR, 1'b1, 2'b00));
    tbl.push_back(decode(I_OR, 2'b00));
    tbl.push_back(exr(I_OR, 3'b011));
    tbl.push_back(aluwb(I_OR, 2'b00));
    tbl.push_back(fetch(I_SLT, 1'b1, 2'b00));
    tbl.push_back(decode(I_SLT, 2'b00));
    tbl.push_back(exr(I_SLT, 3'b101));
    tbl.push_back(aluwb(I_SLT, 2'b00));
    tbl.push_back(fetch(I_SLL, 1'b1, 2'b00));
    tbl.push_back(decode(I_SLL, 2'b00));
    tbl.push_back(exr(I_SLL, 3'b000));
    tbl.push_back(aluwb(I_SLL, 2'b00));
    // I-type: bit 30 set must still add; slti
    tbl.push_back(fetch(I_ADDI, 1'b1, 2'b00));
    tbl.push_back(decode(I_ADDI, 2'b00));
    tbl.push_back(mk(I_ADDI, 0, 1, 4'd7, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0));
    tbl.push_back(aluwb(I_ADDI, 2'b00));
    tbl.push_back(fetch(I_SLTI, 1'b1, 2'b00));
    tbl.push_back(decode(I_SLTI, 2'b00));
    tbl.push_back(mk(I_SLTI, 0, 1, 4'd7, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b101, 2'b00, 0));
    tbl.push_back(aluwb(I_SLTI, 2'b00));
    // jal
    tbl.push_back(fetch(I_JAL, 1'b1, 2'b11));
    tbl.push_back(decode(I_JAL, 2'b11));
    tbl.push_back(mk(I_JAL, 0, 1, 4'd10, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 0));
    tbl.push_back(aluwb(I_JAL, 2'b11));
    // sw with one MEMWRITE stall
    tbl.push_back(fetch(I_SW, 1'b1, 2'b01));
    tbl.push_back(decode(I_SW, 2'b01));
    tbl.push_back(mk(I_SW, 0, 1, 4'd2, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0));
    tbl.push_back(mk(I_SW, 0, 0, 4'd5, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0));
    tbl.push_back(mk(I_SW, 0, 1, 4'd5, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0));
    // unknown opcode
    tbl.push_back(fetch(I_ILL, 1'b1, 2'b00));
    tbl.push_back(decode(I_ILL, 2'b00));
`ifdef ILLEGAL_INSTR_TRAP_EN
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(I_ADD, 0, 1, 4'd11, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1));
`else
    tbl.push_back(fetch(I_ADD, 1'b0, 2'b00));
    tbl.push_back(fetch(I_ADD, 1'b0, 2'b00));
`endif

    // Reset with mem_ready high: FETCH outputs must still be masked.
    rst_n     = 1'b0;
    instr     = I_ADD;
    zero      = 1'b0;
    mem_ready = 1'b1;
    #2;
    check_reset_zero("reset_hold");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      run_row(tbl[i], $sformatf("row%0d", i));

    // Reset pulse: recovers from TRAP or FETCH alike.
    #1 rst_n = 1'b0;
    #1 check_reset_zero("reset_pulse");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // sw interrupted by reset while MEMWRITE is stalled
    run_row(fetch(I_SW, 1'b1, 2'b01), "rw_fetch");
    run_row(decode(I_SW, 2'b01), "rw_decode");
    run_row(mk(I_SW, 0, 1, 4'd2, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0), "rw_memadr");
    instr     = I_SW;
    mem_ready = 1'b0;
    #2;
    n_tests++;
    if (state_dbg !== 4'd5 || mem_req !== 1'b1 || mem_write !== 1'b1) begin
      n_fail++;
      $display("FAIL rw_stall: got state %0d req %b wr %b want 5 1 1",
               state_dbg, mem_req, mem_write);
    end
    rst_n = 1'b0;
    #1;
    check_reset_zero("rw_async_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_row(fetch(I_SW, 1'b0, 2'b01), "rw_release_stall");
    run_row(fetch(I_SW, 1'b1, 2'b01), "rw_release_fetch");
    run_row(decode(I_SW, 2'b01), "rw_release_decode");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle RV32I core. Sequences fetch, decode, execute, memory and writeback.
- Drives the register file write enable, the instruction register load, PC update, ALU operand and operation selects, result mux, and the shared instruction/data memory request.
- Supports lw, sw, R-type ALU, I-type ALU, beq and jal.
- Memory accesses use a req/ready handshake, so wait states stall the FSM in place.

Parameters:
- RESET_STATE_W, 4, width of the state register. Also the width of the debug state output.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- instr  input  32  instruction register contents; opcode = instr[6:0], funct3 = instr[14:12], funct7b5 = instr[30].
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current access this cycle.
- mem_req  output  1  memory access request.
- mem_write  output  1  request is a store.
- adr_src  output  1  address select: 0 = PC, 1 = result.
- ir_write  output  1  load instruction register.
- pc_en  output  1  PC register enable.
- reg_write  output  1  register file write_en_3.
- result_src  output  2  result mux: 00 = ALUOut, 01 = memory data, 10 = ALU result.
- alu_src_a  output  2  ALU operand A: 00 = PC, 01 = old PC, 10 = rd1.
- alu_src_b  output  2  ALU operand B: 00 = rd2, 01 = immediate, 10 = constant 4.
- alu_ctrl  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- imm_src  output  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- illegal_instr  output  1  see Optional Feature.
- state_dbg  output  RESET_STATE_W  current state.

Behaviour:
- Reset: rst_n low forces state = FETCH immediately and holds every output at 0, including state_dbg = FETCH encoding 0. Reset asserted mid-access abandons the access; the first cycle after release is FETCH.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11.
- Moore outputs per state (all others 0):
  - FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10. ir_write=mem_ready, pc_en=mem_ready.
  - DECODE: alu_src_a=01, alu_src_b=01, add (branch target into ALUOut).
  - MEMADR: alu_src_a=10, alu_src_b=01, add.
  - MEMREAD: mem_req=1, adr_src=1, result_src=00.
  - MEMWRITE: mem_req=1, mem_write=1, adr_src=1, result_src=00.
  - MEMWB: result_src=01, reg_write=1.
  - EXECUTER: alu_src_a=10, alu_src_b=00, ALU op from funct3/funct7b5.
  - EXECUTEI: alu_src_a=10, alu_src_b=01, ALU op from funct3 (no sub).
  - ALUWB: result_src=00, reg_write=1.
  - BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00, pc_en=zero.
  - JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_en=1.
- ALU decode: funct3 000 gives add, or sub when R-type and funct7b5=1. 010 gives slt, 110 gives or, 111 gives and. Any other funct3 gives add.
- imm_src is decoded combinationally from opcode in every state: lw/I-ALU 00, sw 01, beq 10, jal 11, other 00.
- Transitions:
  - FETCH to DECODE on mem_ready; otherwise stay.
  - DECODE by opcode: 0000011/0100011 to MEMADR, 0110011 to EXECUTER, 0010011 to EXECUTEI, 1100011 to BEQ, 1101111 to JAL. Any other opcode to FETCH.
  - MEMADR to MEMREAD for lw, to MEMWRITE for sw.
  - MEMREAD to MEMWB on mem_ready.
  - MEMWRITE to FETCH on mem_ready.
  - MEMWB, ALUWB and BEQ to FETCH.
  - EXECUTER, EXECUTEI and JAL to ALUWB.
- Latency with zero memory wait: R/I-ALU 4 cycles, lw 5, sw 4, beq 3, jal 4. Each mem_ready=0 cycle adds 1.
- mem_req stays high and addresses stay stable while waiting. ir_write, pc_en and reg_write never pulse during a stalled cycle.
- reg_write is high for exactly one cycle per writing instruction. Writes with rd=x0 are the register file's concern; the controller does not suppress them.

Optional Feature:
- Macro ILLEGAL_INSTR_TRAP_EN.
- Defined: an unknown opcode in DECODE goes to TRAP. TRAP holds all strobes at 0, sets illegal_instr=1, and stays there until rst_n is asserted.
- Undefined: an unknown opcode returns to FETCH as a NOP, TRAP is unreachable, and illegal_instr is tied to 0.

Test Plan:
- Reset release with mem_ready=1, instr=0x002081B3 (add x3,x1,x2) -> states 0,1,6,8,0. reg_write high only in cycle 4. alu_ctrl=000 in EXECUTER.
- lw 0x0000A183 with mem_ready low for 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0. mem_req and adr_src=1 held through the wait. reg_write a single pulse with result_src=01.
- beq 0x00208463, zero=1 then repeat with zero=0 -> 3 cycles each. pc_en in BEQ is 1 in the first run and 0 in the second. imm_src=10.
- sub 0x402081B3 -> alu_ctrl=001 in EXECUTER. jal 0x008000EF -> JAL state asserts pc_en=1, alu_src_a=01, alu_src_b=10, then ALUWB writes.
- rst_n pulsed low during MEMWRITE while mem_ready=0 -> all outputs drop to 0 asynchronously, and FETCH is entered on release.
- Opcode 0x7F -> with ILLEGAL_INSTR_TRAP_EN: TRAP, illegal_instr=1, stuck until reset. Without it: back to FETCH after DECODE, illegal_instr=0.
